// File: rtl/spd_pkg.sv
// spd_pkg: shared constants, types and the timing-field extractor for spd_timing_decoder.
// Contents: SPD byte addresses, required-byte mask, MTB size, error codes, FSM states.
// No ports; imported by spd_timing_decoder and spd_seq_divider.
package spd_pkg;

  // SPD byte addresses used by the decoder
  localparam int ADDR_TYPE    = 2;
  localparam int ADDR_MTB_DD  = 10;
  localparam int ADDR_MTB_DS  = 11;
  localparam int ADDR_TCKMIN  = 12;
  localparam int ADDR_TAA     = 16;
  localparam int ADDR_TWR     = 17;
  localparam int ADDR_TRCD    = 18;
  localparam int ADDR_TRRD    = 19;
  localparam int ADDR_TRP     = 20;
  localparam int ADDR_TRASRC  = 21;
  localparam int ADDR_TRAS_L  = 22;
  localparam int ADDR_TRC_L   = 23;
  localparam int ADDR_TRFC_L  = 24;
  localparam int ADDR_TRFC_H  = 25;
  localparam int ADDR_TWTR    = 26;
  localparam int ADDR_TRTP    = 27;
  localparam int ADDR_TFAW_H  = 28;
  localparam int ADDR_TFAW_L  = 29;

  localparam int NUM_ADDR = 30;

  // bits 2, 10, 11, 12 and 16..29
  localparam logic [NUM_ADDR-1:0] REQ_MASK = 30'h3FFF_1C04;

  localparam int          MTB_PS    = 125;
  localparam logic [7:0]  DDR3_TYPE = 8'h0B;

  localparam int DIV_W  = 24;
  localparam int DVSR_W = 16;

  // Result slots, in the order the divider processes them
  localparam int NUM_T = 11;
  localparam int T_AA  = 0;
  localparam int T_RCD = 1;
  localparam int T_RP  = 2;
  localparam int T_RAS = 3;
  localparam int T_RC  = 4;
  localparam int T_RFC = 5;
  localparam int T_WR  = 6;
  localparam int T_RRD = 7;
  localparam int T_WTR = 8;
  localparam int T_RTP = 9;
  localparam int T_FAW = 10;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_MISSING  = 3'd1,
    ERR_NOT_DDR3 = 3'd2,
    ERR_BAD_MTB  = 3'd3,
    ERR_TCK      = 3'd4
  } err_code_e;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_CHECK,
    ST_DIV,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef logic [NUM_ADDR-1:0][7:0] spd_img_t;

  // Timing value in MTB units for result slot idx; slots past the end give 0.
  function automatic logic [15:0] timing_mtb(input spd_img_t img, input logic [3:0] idx);
    logic [15:0] t;
    t = '0;
    case (idx)
      4'd0:    t = {8'h00, img[ADDR_TAA]};
      4'd1:    t = {8'h00, img[ADDR_TRCD]};
      4'd2:    t = {8'h00, img[ADDR_TRP]};
      4'd3:    t = {4'h0, img[ADDR_TRASRC][3:0], img[ADDR_TRAS_L]};
      4'd4:    t = {4'h0, img[ADDR_TRASRC][7:4], img[ADDR_TRC_L]};
      4'd5:    t = {img[ADDR_TRFC_H], img[ADDR_TRFC_L]};
      4'd6:    t = {8'h00, img[ADDR_TWR]};
      4'd7:    t = {8'h00, img[ADDR_TRRD]};
      4'd8:    t = {8'h00, img[ADDR_TWTR]};
      4'd9:    t = {8'h00, img[ADDR_TRTP]};
      4'd10:   t = {4'h0, img[ADDR_TFAW_H][3:0], img[ADDR_TFAW_L]};
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/spd_seq_divider.sv
// spd_seq_divider: 24-bit / 16-bit unsigned restoring divider, one quotient bit per cycle.
// Latency: i_start sampled on the load edge, then 24 iterate edges; o_done/o_quotient valid
//   combinationally during the cycle before the last iterate edge. i_start ignored while o_busy.
// Ports: i_clk, i_rst (sync, active-high), i_start, i_dividend[24], i_divisor[16],
//   o_busy, o_done (last-iteration strobe), o_quotient[24] (quotient after the coming edge).
module spd_seq_divider
  import spd_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DIV_W-1:0]  i_dividend,
  input  logic [DVSR_W-1:0] i_divisor,
  output logic              o_busy,
  output logic              o_done,
  output logic [DIV_W-1:0]  o_quotient
);

  logic [DIV_W-1:0]  quo_q;
  logic [DVSR_W-1:0] rem_q;
  logic [4:0]        cnt_q;
  logic              busy_q;

  logic [DVSR_W:0]   shifted;
  logic              ge;
  logic [DVSR_W-1:0] rem_nxt;
  logic [DIV_W-1:0]  quo_nxt;

  // Remainder stays below the divisor, so the subtraction always fits DVSR_W bits.
  always_comb begin
    shifted = {rem_q, quo_q[DIV_W-1]};
    ge      = (shifted >= {1'b0, i_divisor});
    rem_nxt = ge ? DVSR_W'(shifted - {1'b0, i_divisor}) : shifted[DVSR_W-1:0];
    quo_nxt = {quo_q[DIV_W-2:0], ge};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (i_start && !busy_q) begin
      quo_q  <= i_dividend;
      rem_q  <= '0;
      cnt_q  <= 5'(DIV_W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q - 5'd1;
      if (cnt_q == 5'd1) busy_q <= 1'b0;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = busy_q && (cnt_q == 5'd1);
  assign o_quotient = quo_nxt;

endmodule

// File: rtl/spd_timing_decoder.sv
// spd_timing_decoder: captures DDR3 SPD bytes, validates them and converts timing fields
//   into ceil(t_ps/TCK_PS) controller cycles (saturating at 2^OUT_W-1).
// Latency: error flagged 1 edge after i_spd_last; o_done 277 edges after i_spd_last.
// Backpressure: none; the SPD stream is consumed unconditionally while collecting.
// Ports: i_clk, i_rst (sync active-high), i_spd_valid/addr/data/last (SPD byte stream),
//   o_busy, o_done, o_error, o_error_code[3], o_taa..o_tfaw[OUT_W] cycle counts.
module spd_timing_decoder
  import spd_pkg::*;
#(
  parameter int TCK_PS = 2500,
  parameter int OUT_W  = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_spd_valid,
  input  logic [7:0]       i_spd_addr,
  input  logic [7:0]       i_spd_data,
  input  logic             i_spd_last,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [2:0]       o_error_code,
  output logic [OUT_W-1:0] o_taa,
  output logic [OUT_W-1:0] o_trcd,
  output logic [OUT_W-1:0] o_trp,
  output logic [OUT_W-1:0] o_tras,
  output logic [OUT_W-1:0] o_trc,
  output logic [OUT_W-1:0] o_trfc,
  output logic [OUT_W-1:0] o_twr,
  output logic [OUT_W-1:0] o_trrd,
  output logic [OUT_W-1:0] o_twtr,
  output logic [OUT_W-1:0] o_trtp,
  output logic [OUT_W-1:0] o_tfaw
);

  localparam logic [31:0]      TCK_U    = 32'(TCK_PS);
  localparam logic [DIV_W:0]   SAT_MAX  = {{(DIV_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic [DIV_W-1:0] ROUND_UP = DIV_W'(TCK_PS - 1);

  state_e          state_q, state_d;
  spd_img_t        spd_q;
  logic [NUM_ADDR-1:0] seen_q;
  logic [3:0]      idx_q;
  err_code_e       code_q, check_code;
  logic [OUT_W-1:0] res_q [NUM_T];

  logic             capture_hit;
  logic [15:0]      tck_min_ps;
  logic [15:0]      t_mtb;
  logic [DIV_W-1:0] dividend;
  logic             div_start, div_busy, div_done;
  logic [DIV_W-1:0] div_quot;
  logic [OUT_W-1:0] res_val;

  assign capture_hit = i_spd_valid && (state_q == ST_COLLECT) &&
                       (i_spd_addr < 8'(NUM_ADDR)) && REQ_MASK[i_spd_addr[4:0]];

  // Validation, in priority order; runs on the captured image in CHECK.
  always_comb begin
    check_code = ERR_NONE;
    tck_min_ps = 16'(spd_q[ADDR_TCKMIN]) * 16'(MTB_PS);
    if (seen_q != REQ_MASK)
      check_code = ERR_MISSING;
    else if (spd_q[ADDR_TYPE] != DDR3_TYPE)
      check_code = ERR_NOT_DDR3;
    else if ((spd_q[ADDR_MTB_DD] != 8'd1) || (spd_q[ADDR_MTB_DS] != 8'd8))
      check_code = ERR_BAD_MTB;
    else if ({16'd0, tck_min_ps} > TCK_U)
      check_code = ERR_TCK;
  end

  // Dividend = t_ps + TCK_PS - 1 turns the floor divider into a ceiling.
  always_comb begin
    t_mtb    = timing_mtb(spd_q, idx_q);
    dividend = (DIV_W'(t_mtb) * DIV_W'(MTB_PS)) + ROUND_UP;
  end

  // A new division starts the cycle after the previous one wrote its result.
  assign div_start = (state_q == ST_DIV) && !div_busy && (idx_q < 4'(NUM_T));

  spd_seq_divider u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (div_start),
    .i_dividend (dividend),
    .i_divisor  (DVSR_W'(TCK_PS)),
    .o_busy     (div_busy),
    .o_done     (div_done),
    .o_quotient (div_quot)
  );

  assign res_val = ({1'b0, div_quot} > SAT_MAX) ? {OUT_W{1'b1}} : div_quot[OUT_W-1:0];

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_COLLECT;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (i_spd_last) state_d = ST_CHECK;
      ST_CHECK:   state_d = (check_code != ERR_NONE) ? ST_ERROR : ST_DIV;
      ST_DIV:     if (idx_q == 4'(NUM_T)) state_d = ST_DONE;
      default:    state_d = state_q;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy       = (state_q == ST_DIV);
    o_done       = (state_q == ST_DONE);
    o_error      = (state_q == ST_ERROR);
    o_error_code = code_q;
  end

  // Datapath: capture, error code, per-slot results
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      spd_q  <= '0;
      seen_q <= '0;
      idx_q  <= '0;
      code_q <= ERR_NONE;
      for (int i = 0; i < NUM_T; i++) res_q[i] <= '0;
    end else begin
      if (capture_hit) begin
        spd_q[i_spd_addr[4:0]]  <= i_spd_data;
        seen_q[i_spd_addr[4:0]] <= 1'b1;
      end
      if (state_q == ST_CHECK) code_q <= check_code;
      if ((state_q == ST_DIV) && div_done) begin
        res_q[idx_q] <= res_val;
        idx_q        <= idx_q + 4'd1;
      end
    end
  end

  assign o_taa  = res_q[T_AA];
  assign o_trcd = res_q[T_RCD];
  assign o_trp  = res_q[T_RP];
  assign o_tras = res_q[T_RAS];
  assign o_trc  = res_q[T_RC];
  assign o_trfc = res_q[T_RFC];
  assign o_twr  = res_q[T_WR];
  assign o_trrd = res_q[T_RRD];
  assign o_twtr = res_q[T_WTR];
  assign o_trtp = res_q[T_RTP];
  assign o_tfaw = res_q[T_FAW];

endmodule

// File: tb/tb_spd_timing_decoder.sv
// Bench for spd_timing_decoder: four instances share one SPD stream
// (TCK 2500/OUT_W 10, TCK 1000, TCK 1250, TCK 2500/OUT_W 8).
module tb_spd_timing_decoder;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       vld  = 1'b0;
  logic       last = 1'b0;
  logic [7:0] addr = 8'd0;
  logic [7:0] data = 8'd0;

  logic [9:0] t0 [11];
  logic [9:0] t1 [11];
  logic [9:0] t2 [11];
  logic [7:0] t3 [11];
  logic       busy [4];
  logic       done [4];
  logic       err  [4];
  logic [2:0] code [4];

  int total = 0;
  int bad   = 0;

  // aa,rcd,rp,ras,rc,rfc,wr,rrd,wtr,rtp,faw
  int exp2500 [11] = '{6, 6, 6, 14, 20, 104, 6, 3, 3, 3, 12};
  int exp1250 [11] = '{11, 11, 11, 28, 39, 208, 12, 6, 6, 6, 24};
  string tn [11] = '{"taa", "trcd", "trp", "tras", "trc", "trfc", "twr", "trrd", "twtr", "trtp", "tfaw"};

  always #5 clk = ~clk;

  spd_timing_decoder #(.TCK_PS(2500), .OUT_W(10)) u0 (
    .i_clk(clk), .i_rst(rst), .i_spd_valid(vld), .i_spd_addr(addr), .i_spd_data(data),
    .i_spd_last(last), .o_busy(busy[0]), .o_done(done[0]), .o_error(err[0]), .o_error_code(code[0]),
    .o_taa(t0[0]), .o_trcd(t0[1]), .o_trp(t0[2]), .o_tras(t0[3]), .o_trc(t0[4]), .o_trfc(t0[5]),
    .o_twr(t0[6]), .o_trrd(t0[7]), .o_twtr(t0[8]), .o_trtp(t0[9]), .o_tfaw(t0[10]));

  spd_timing_decoder #(.TCK_PS(1000), .OUT_W(10)) u1 (
    .i_clk(clk), .i_rst(rst), .i_spd_valid(vld), .i_spd_addr(addr), .i_spd_data(data),
    .i_spd_last(last), .o_busy(busy[1]), .o_done(done[1]), .o_error(err[1]), .o_error_code(code[1]),
    .o_taa(t1[0]), .o_trcd(t1[1]), .o_trp(t1[2]), .o_tras(t1[3]), .o_trc(t1[4]), .o_trfc(t1[5]),
    .o_twr(t1[6]), .o_trrd(t1[7]), .o_twtr(t1[8]), .o_trtp(t1[9]), .o_tfaw(t1[10]));

  spd_timing_decoder #(.TCK_PS(1250), .OUT_W(10)) u2 (
    .i_clk(clk), .i_rst(rst), .i_spd_valid(vld), .i_spd_addr(addr), .i_spd_data(data),
    .i_spd_last(last), .o_busy(busy[2]), .o_done(done[2]), .o_error(err[2]), .o_error_code(code[2]),
    .o_taa(t2[0]), .o_trcd(t2[1]), .o_trp(t2[2]), .o_tras(t2[3]), .o_trc(t2[4]), .o_trfc(t2[5]),
    .o_twr(t2[6]), .o_trrd(t2[7]), .o_twtr(t2[8]), .o_trtp(t2[9]), .o_tfaw(t2[10]));

  spd_timing_decoder #(.TCK_PS(2500), .OUT_W(8)) u3 (
    .i_clk(clk), .i_rst(rst), .i_spd_valid(vld), .i_spd_addr(addr), .i_spd_data(data),
    .i_spd_last(last), .o_busy(busy[3]), .o_done(done[3]), .o_error(err[3]), .o_error_code(code[3]),
    .o_taa(t3[0]), .o_trcd(t3[1]), .o_trp(t3[2]), .o_tras(t3[3]), .o_trc(t3[4]), .o_trfc(t3[5]),
    .o_twr(t3[6]), .o_trrd(t3[7]), .o_twtr(t3[8]), .o_trtp(t3[9]), .o_tfaw(t3[10]));

  typedef struct {
    string      name;
    logic [7:0] b2, b11, b18, b24, b25;
    bit         skip27;
    int         code0;   // u0 error code (0 = expect done)
    int         rcd0;
    int         rfc0;
    int         rfc3;    // u3, OUT_W=8
    int         code1;   // u1, TCK 1000
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic put(input int a, input logic [7:0] d, input bit l);
    vld  = 1'b1;
    addr = 8'(a);
    data = d;
    last = l;
    @(posedge clk);
    #1;
    vld  = 1'b0;
    last = 1'b0;
  endtask

  // Byte 29 goes out together with i_spd_last; returns #1 after that edge (edge N).
  task automatic send_image(input logic [7:0] b2, input logic [7:0] b11, input logic [7:0] b18,
                            input logic [7:0] b24, input logic [7:0] b25, input bit skip27);
    logic [7:0] img [30];
    int al [18] = '{2, 10, 11, 12, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29};
    for (int i = 0; i < 30; i++) img[i] = 8'h00;
    img[2]  = b2;    img[10] = 8'h01; img[11] = b11;   img[12] = 8'h0A;
    img[16] = 8'h69; img[17] = 8'h78; img[18] = b18;   img[19] = 8'h3C;
    img[20] = 8'h69; img[21] = 8'h11; img[22] = 8'h18; img[23] = 8'h81;
    img[24] = b24;   img[25] = b25;   img[26] = 8'h3C; img[27] = 8'h3C;
    img[28] = 8'h00; img[29] = 8'hF0;
    put(3, 8'hAA, 1'b0);
    put(40, 8'h55, 1'b0);
    put(2, ~b2, 1'b0);   // overwritten below
    for (int i = 0; i < 18; i++) begin
      if (skip27 && al[i] == 27) continue;
      put(al[i], img[al[i]], al[i] == 29);
    end
  endtask

  task automatic send_default();
    send_image(8'h0B, 8'h08, 8'h69, 8'h20, 8'h08, 1'b0);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done[0] || err[0]) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL wait_end timeout actual=%0d cycles required<400", n);
    end
  endtask

  task automatic chk_u0_all(input string pfx);
    for (int i = 0; i < 11; i++) chk($sformatf("%s_u0_%s", pfx, tn[i]), int'(t0[i]), exp2500[i]);
  endtask

  initial begin
    tbl[0] = '{"default",  8'h0B, 8'h08, 8'h69, 8'h20, 8'h08, 1'b0, 0, 6, 104, 104, 4};
    tbl[1] = '{"no_b27",   8'h0B, 8'h08, 8'h69, 8'h20, 8'h08, 1'b1, 1, 0, 0, 0, 1};
    tbl[2] = '{"not_ddr3", 8'h0C, 8'h08, 8'h69, 8'h20, 8'h08, 1'b0, 2, 0, 0, 0, 2};
    tbl[3] = '{"bad_mtb",  8'h0B, 8'h0A, 8'h69, 8'h20, 8'h08, 1'b0, 3, 0, 0, 0, 3};
    tbl[4] = '{"prio_mis", 8'h0C, 8'h08, 8'h69, 8'h20, 8'h08, 1'b1, 1, 0, 0, 0, 1};
    tbl[5] = '{"rcd_exact",8'h0B, 8'h08, 8'h50, 8'h20, 8'h08, 1'b0, 0, 4, 104, 104, 4};
    tbl[6] = '{"rfc_sat",  8'h0B, 8'h08, 8'h69, 8'hFF, 8'hFF, 1'b0, 0, 6, 1023, 255, 4};

    // Reset state
    do_reset();
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_error", int'(err[0]), 0);
    chk("rst_code", int'(code[0]), 0);
    for (int i = 0; i < 11; i++) chk($sformatf("rst_%s", tn[i]), int'(t0[i]), 0);

    // Table-driven scenarios
    for (int v = 0; v < 7; v++) begin
      do_reset();
      send_image(tbl[v].b2, tbl[v].b11, tbl[v].b18, tbl[v].b24, tbl[v].b25, tbl[v].skip27);
      wait_end();
      chk({tbl[v].name, "_code"},  int'(code[0]), tbl[v].code0);
      chk({tbl[v].name, "_error"}, int'(err[0]), int'(tbl[v].code0 != 0));
      chk({tbl[v].name, "_done"},  int'(done[0]), int'(tbl[v].code0 == 0));
      chk({tbl[v].name, "_rcd"},   int'(t0[1]), tbl[v].rcd0);
      chk({tbl[v].name, "_rfc"},   int'(t0[5]), tbl[v].rfc0);
      chk({tbl[v].name, "_rfc8"},  int'(t3[5]), tbl[v].rfc3);
      chk({tbl[v].name, "_code_tck1000"}, int'(code[1]), tbl[v].code1);
      if (tbl[v].code0 != 0) begin
        for (int i = 0; i < 11; i++) chk({tbl[v].name, "_zero_", tn[i]}, int'(t0[i]), 0);
      end
    end

    // Exact cycle timing, partial results, all outputs of all instances
    do_reset();
    send_default();
    for (int k = 1; k <= 277; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        chk("n1_busy", int'(busy[0]), 1);
        chk("n1_done", int'(done[0]), 0);
        chk("n1_tck1000_error", int'(err[1]), 1);
        chk("n1_tck1000_code", int'(code[1]), 4);
      end
      if (k == 25) chk("n25_taa_not_yet", int'(t0[0]), 0);
      if (k == 26) begin
        chk("n26_taa", int'(t0[0]), 6);
        chk("n26_trcd_not_yet", int'(t0[1]), 0);
      end
      if (k == 276) begin
        chk("n276_busy", int'(busy[0]), 1);
        chk("n276_done", int'(done[0]), 0);
        chk("n276_tfaw", int'(t0[10]), 12);
      end
      if (k == 277) begin
        chk("n277_done", int'(done[0]), 1);
        chk("n277_busy", int'(busy[0]), 0);
      end
    end
    chk_u0_all("full");
    chk("tck1250_done", int'(done[2]), 1);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("tck1250_%s", tn[i]), int'(t2[i]), exp1250[i]);
      chk($sformatf("tck1000_zero_%s", tn[i]), int'(t1[i]), 0);
      chk($sformatf("w8_%s", tn[i]), int'(t3[i]), exp2500[i]);
    end
    chk("tck1000_busy", int'(busy[1]), 0);
    chk("tck1000_done", int'(done[1]), 0);

    // Traffic after DONE is ignored
    put(16, 8'h00, 1'b1);
    put(18, 8'hFF, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    chk("post_done_busy", int'(busy[0]), 0);
    chk("post_done_done", int'(done[0]), 1);
    chk_u0_all("post_done");

    // Reset in the middle of DIV, then replay
    do_reset();
    send_default();
    repeat (99) @(posedge clk);
    #1;
    chk("n99_taa", int'(t0[0]), 6);
    chk("n99_trp", int'(t0[2]), 6);
    chk("n99_tras_not_yet", int'(t0[3]), 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_busy", int'(busy[0]), 0);
    chk("midrst_done", int'(done[0]), 0);
    chk("midrst_error", int'(err[0]), 0);
    for (int i = 0; i < 11; i++) chk($sformatf("midrst_%s", tn[i]), int'(t0[i]), 0);
    send_default();
    wait_end();
    chk("replay_done", int'(done[0]), 1);
    chk_u0_all("replay");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
